chip2chip_slave_ctrl: RTL and testbench

Slave-side controller for the Chip2Chip link. It is the responder to the master board's request/notice handshake. It synchronises the master's cross-board control lines and lights a request LED. It then waits for the local user button, returns an acknowledge, captures the 8-bit payload, and shows a "received" LED for a fixed display period before re-arming.

---
 rtl/chip2chip_slave_ctrl.sv | 174 +++++++++++++++++
 tb/tb_chip2chip_slave_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/chip2chip_slave_ctrl.sv
// -----------------------------------------------------------------------------
// chip2chip_slave_ctrl
//
// Slave-side responder for the Chip2Chip request/notice handshake. The master's
// cross-board control lines are brought into the clk domain through two-flop
// synchronisers. A pending request is shown on led_req until the local user
// presses the button. The controller then raises ack, captures the payload when
// notice arrives, holds ack until the master releases both lines, and finally
// lights led_done for SHOW_CYCLES cycles before re-arming.
//
// Parameters:
//   SHOW_CYCLES  cycles led_done stays lit (must be >= 1)
//   CNT_W        display counter width, 2**CNT_W > SHOW_CYCLES
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   request     master request line (asynchronous to clk)
//   notice      master data-valid line (asynchronous to clk)
//   data_in     master payload, stable while notice is high
//   btn_ack     one-cycle debounced button pulse
//   ack         acknowledge back to the master
//   led_req     request waiting for the user
//   led_done    display period in progress
//   data_out    last captured payload
//   data_valid  one-cycle pulse when data_out updates
//   state_o     current state encoding for debug LEDs
// -----------------------------------------------------------------------------
module chip2chip_slave_ctrl #(
  parameter int unsigned SHOW_CYCLES = 100_000_000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       request,
  input  logic       notice,
  input  logic [7:0] data_in,
  input  logic       btn_ack,
  output logic       ack,
  output logic       led_req,
  output logic       led_done,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BTN = 3'd1,
    SEND_ACK = 3'd2,
    WAIT_REL = 3'd3,
    SHOW     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHOW_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             capture;

  logic             req_meta;
  logic             req_s;
  logic             ntc_meta;
  logic             ntc_s;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers for the master's control lines. data_in is left
  // unsynchronised: it is only looked at once notice_s is high, and the master
  // keeps it stable for the whole notice phase.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its source; with blocking assignments
  // the two synchroniser stages would collapse into one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
      ntc_meta <= 1'b0;
      ntc_s    <= 1'b0;
    end else begin
      req_meta <= request;
      req_s    <= req_meta;
      ntc_meta <= notice;
      ntc_s    <= ntc_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // State and display counter registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The counter defaults to zero so it can only be nonzero
  // while sitting in SHOW, and it is cleared on the exit cycle.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement;
  // a path that left one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    capture   = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_s) state_nxt = WAIT_BTN;
      end

      WAIT_BTN: begin
        // A withdrawal takes priority over a button press in the same cycle.
        if (!req_s)       state_nxt = IDLE;
        else if (btn_ack) state_nxt = SEND_ACK;
      end

      SEND_ACK: begin
        if (ntc_s) begin
          capture   = 1'b1;
          state_nxt = WAIT_REL;
        end else if (!req_s) begin
          state_nxt = IDLE;
        end
      end

      WAIT_REL: begin
        // Four-phase handshake: ack is held until the master has dropped both
        // of its lines.
        if (!ntc_s && !req_s) state_nxt = SHOW;
      end

      SHOW: begin
        if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. These are decoded from the next state, so each output
  // changes on the same edge as the state it belongs to.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack        <= 1'b0;
      led_req    <= 1'b0;
      led_done   <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= 8'h00;
    end else begin
      ack        <= (state_nxt == SEND_ACK) || (state_nxt == WAIT_REL);
      led_req    <= (state_nxt == WAIT_BTN);
      led_done   <= (state_nxt == SHOW);
      data_valid <= capture;
      if (capture) data_out <= data_in;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_chip2chip_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_chip2chip_slave_ctrl
//
// Directed bench for chip2chip_slave_ctrl with SHOW_CYCLES = 10. Inputs are
// changed and outputs are sampled 1 ns after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_chip2chip_slave_ctrl;

  localparam int SHOW = 10;

  logic       clk;
  logic       rst_n;
  logic       request;
  logic       notice;
  logic [7:0] data_in;
  logic       btn_ack;
  logic       ack;
  logic       led_req;
  logic       led_done;
  logic [7:0] data_out;
  logic       data_valid;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  chip2chip_slave_ctrl #(
    .SHOW_CYCLES(SHOW),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .request   (request),
    .notice    (notice),
    .data_in   (data_in),
    .btn_ack   (btn_ack),
    .ack       (ack),
    .led_req   (led_req),
    .led_done  (led_done),
    .data_out  (data_out),
    .data_valid(data_valid),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps until state_o reaches target or the budget runs out, then checks.
  task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
    int n = 0;
    while (state_o !== target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(state_o), 32'(target));
  endtask

  task automatic pulse_btn();
    btn_ack = 1'b1;
    tick();
    btn_ack = 1'b0;
  endtask

  // Raises notice with a payload and waits for the data_valid pulse; checks
  // the captured value and that the pulse lasts exactly one cycle.
  task automatic capture(input string tag, input logic [7:0] d);
    int n = 0;
    data_in = d;
    notice  = 1'b1;
    while (!data_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_dv_hi"},  32'(data_valid), 32'd1);
    check({tag, "_data"},   32'(data_out),   32'(d));
    check({tag, "_st_rel"}, 32'(state_o),    32'd3);
    tick();
    check({tag, "_dv_lo"},  32'(data_valid), 32'd0);
    check({tag, "_ack_rel"}, 32'(ack),       32'd1);
  endtask

  // Drops both master lines, expects SHOW, and measures the led_done width.
  task automatic release_and_show(input string tag);
    int n = 0;
    notice  = 1'b0;
    request = 1'b0;
    wait_state({tag, "_show"}, 3'd4, 10);
    check({tag, "_ack_off"}, 32'(ack), 32'd0);
    while (led_done && n < 50) begin
      n++;
      tick();
    end
    check({tag, "_done_len"}, 32'(n), 32'(SHOW));
    check({tag, "_idle"}, 32'(state_o), 32'd0);
  endtask

  initial begin
    int   n;
    logic seen;

    rst_n   = 1'b0;
    request = 1'b1;
    notice  = 1'b0;
    data_in = 8'h00;
    btn_ack = 1'b0;

    // Reset held for three cycles with request high.
    repeat (3) tick();
    check("rst_ack",   32'(ack),        32'd0);
    check("rst_lreq",  32'(led_req),    32'd0);
    check("rst_ldone", 32'(led_done),   32'd0);
    check("rst_data",  32'(data_out),   32'h00);
    check("rst_dv",    32'(data_valid), 32'd0);
    check("rst_state", 32'(state_o),    32'd0);

    // Release: two synchroniser stages, then the state register.
    rst_n = 1'b1;
    tick();
    check("rel_e1_state", 32'(state_o), 32'd0);
    tick();
    check("rel_e2_state", 32'(state_o), 32'd0);
    tick();
    check("rel_e3_state", 32'(state_o), 32'd1);
    check("rel_e3_lreq",  32'(led_req), 32'd1);

    // Full transaction with A5.
    pulse_btn();
    check("t1_st_ack", 32'(state_o), 32'd2);
    check("t1_ack",    32'(ack),     32'd1);
    check("t1_lreq",   32'(led_req), 32'd0);
    capture("t1", 8'hA5);
    release_and_show("t1");

    // Withdrawal from WAIT_BTN without a button press.
    request = 1'b1;
    wait_state("wd_wait", 3'd1, 10);
    request = 1'b0;
    seen = 1'b0;
    n = 0;
    while (state_o !== 3'd0 && n < 10) begin
      tick();
      n++;
      if (ack) seen = 1'b1;
    end
    repeat (3) begin
      tick();
      if (ack) seen = 1'b1;
    end
    check("wd_state",    32'(state_o),  32'd0);
    check("wd_ack_seen", 32'(seen),     32'd0);
    check("wd_data",     32'(data_out), 32'hA5);

    // Button pulse arrives on the same cycle request_s falls.
    request = 1'b1;
    wait_state("sim_wait", 3'd1, 10);
    request = 1'b0;
    tick();
    tick();
    pulse_btn();
    check("sim_state", 32'(state_o), 32'd0);
    check("sim_ack",   32'(ack),     32'd0);
    tick();
    check("sim_state2", 32'(state_o), 32'd0);

    // Abort in SEND_ACK: request dropped before notice.
    request = 1'b1;
    wait_state("ab_wait", 3'd1, 10);
    pulse_btn();
    check("ab_st_ack", 32'(state_o), 32'd2);
    check("ab_ack_on", 32'(ack),     32'd1);
    request = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (data_valid) seen = 1'b1;
    end
    check("ab_state",   32'(state_o),  32'd0);
    check("ab_ack_off", 32'(ack),      32'd0);
    check("ab_dv_seen", 32'(seen),     32'd0);
    check("ab_data",    32'(data_out), 32'hA5);

    // Reset in the middle of SHOW, at count 5.
    request = 1'b1;
    wait_state("mr_wait", 3'd1, 10);
    pulse_btn();
    capture("mr", 8'h5A);
    notice  = 1'b0;
    request = 1'b0;
    wait_state("mr_show", 3'd4, 10);
    repeat (5) tick();
    check("mr_still_show", 32'(led_done), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mr_ldone", 32'(led_done), 32'd0);
    check("mr_state", 32'(state_o),  32'd0);
    check("mr_data",  32'(data_out), 32'h00);
    rst_n = 1'b1;
    tick();

    // Fresh transaction after the mid-op reset.
    request = 1'b1;
    wait_state("t2_wait", 3'd1, 10);
    pulse_btn();
    check("t2_ack", 32'(ack), 32'd1);
    capture("t2", 8'h3C);
    release_and_show("t2");
    check("t2_data_hold", 32'(data_out), 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
